pipelined_cla_adder_32: RTL and testbench

PIPELINED_CLA_ADDER_32 -- requirements
Module: pipelined_cla_adder_32

---
 rtl/pipelined_cla_adder_32.sv | 97 +++++++++
 tb/tb_pipelined_cla_adder_32.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder_32.sv
// pipelined_cla_adder_32: two-stage 32-bit carry-lookahead adder with a valid/ready handshake.
// Define PIPE_ADDER_FLAGS_EN to register the overflow and zero flags; otherwise both are tied to 0.
module pipelined_cla_adder_32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] sum,
    output logic        c_out,
    output logic        overflow,
    output logic        zero
);
    // Returns {propagate, generate} of a 4-wide lookahead group.
    function automatic logic [1:0] group_pg(input logic [3:0] p, input logic [3:0] g);
        return {&p, g[3] | (p[3] & g[2]) | (&p[3:2] & g[1]) | (&p[3:1] & g[0])};
    endfunction

    function automatic logic [1:0] block_pg(input logic [15:0] x, input logic [15:0] y);
        logic [3:0] gp;
        logic [3:0] gg;
        for (int i = 0; i < 4; i++)
            {gp[i], gg[i]} = group_pg(x[4*i +: 4] ^ y[4*i +: 4], x[4*i +: 4] & y[4*i +: 4]);
        return group_pg(gp, gg);
    endfunction

    logic [1:0]  p, g, s1_p, s1_g;
    logic [31:0] s1_a, s1_b, nxt_sum;
    logic        s1_c_in, s1_valid, s2_adv, c0, c1;
    logic [16:0] lo;
    logic [15:0] hi;

    assign {p[0], g[0]} = block_pg(a[15:0], b[15:0]);
    assign {p[1], g[1]} = block_pg(a[31:16], b[31:16]);

    assign s2_adv   = s1_valid && (!out_valid || out_ready);
    assign in_ready = rst_n && (!s1_valid || s2_adv);

    assign c0      = s1_g[0] | (s1_p[0] & s1_c_in);
    assign c1      = s1_g[1] | (s1_p[1] & c0);
    assign lo      = {1'b0, s1_a[15:0]} + {1'b0, s1_b[15:0]} + {16'b0, s1_c_in};
    assign hi      = s1_a[31:16] + s1_b[31:16] + {15'b0, c0};
    assign nxt_sum = {hi, lo[15:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_g     <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_c_in  <= 1'b0;
        end else if (in_valid && in_ready) begin
            s1_valid <= 1'b1;
            s1_p     <= p;
            s1_g     <= g;
            s1_a     <= a;
            s1_b     <= b;
            s1_c_in  <= c_in;
        end else if (s2_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            c_out     <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= 1'b1;
            sum       <= nxt_sum;
            c_out     <= c1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef PIPE_ADDER_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (s2_adv) begin
            overflow <= (s1_a[31] == s1_b[31]) && (nxt_sum[31] != s1_a[31]);
            zero     <= nxt_sum == 32'd0;
        end
    end
`else
    assign overflow = 1'b0;
    assign zero     = 1'b0;
`endif
endmodule

// File: tb/tb_pipelined_cla_adder_32.sv
// tb_pipelined_cla_adder_32: directed and random checks of the pipelined 32-bit adder.
module tb_pipelined_cla_adder_32;
`ifdef PIPE_ADDER_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic        clk = 1'b0, rst_n, in_valid, in_ready, c_in, out_valid, out_ready;
    logic        c_out, overflow, zero;
    logic [31:0] a, b, sum;
    int          errors = 0, checks = 0;

    pipelined_cla_adder_32 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y, input logic ci);
        logic [32:0] t;
        logic        ovf, zr;
        t   = {1'b0, x} + {1'b0, y} + {32'b0, ci};
        ovf = FLAGS && (x[31] == y[31]) && (t[31] != x[31]);
        zr  = FLAGS && (t[31:0] == 32'd0);
        return {t[32], t[31:0], ovf, zr};
    endfunction

    task automatic run_one(input string tag, input logic [31:0] x, input logic [31:0] y, input logic ci,
                           input logic [31:0] es, input logic ec, input logic eo, input logic ez);
        @(negedge clk);
        a = x; b = y; c_in = ci; in_valid = 1'b1; out_ready = 1'b1;
        #1 check({tag, "_in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_lat1"}, out_valid, 0);
        @(negedge clk);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_sum"}, sum, es);
        check({tag, "_c_out"}, c_out, ec);
        check({tag, "_ovf"}, overflow, FLAGS ? eo : 1'b0);
        check({tag, "_zero"}, zero, FLAGS ? ez : 1'b0);
        @(negedge clk);
        check({tag, "_drain"}, out_valid, 0);
    endtask

    initial begin
        logic [34:0] exp_q[$];
        int acc = 0, got = 0;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_c_out", c_out, 0);
        rst_n = 1'b1;
        #1 check("post_rst_in_ready", in_ready, 1);

        run_one("case1", 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
        run_one("case2", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_one("case3", 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run_one("ripple", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        run_one("negovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
        run_one("mixed", 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 32'h2222_2222, 1'b0, 1'b0, 1'b0);

        // Backpressure: two sets fill the pipe, the third waits until out_ready rises.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; a = 32'd1; b = 32'd2; c_in = 1'b0;
        #1 check("bp_acc_a", in_ready, 1);
        @(negedge clk);
        a = 32'd10; b = 32'd20;
        #1 check("bp_acc_b", in_ready, 1);
        @(negedge clk);
        a = 32'h100; b = 32'h200;
        #1 check("bp_full", in_ready, 0);
        check("bp_valid", out_valid, 1);
        check("bp_sum_a", sum, 32'd3);
        @(negedge clk);
        #1 check("bp_still_full", in_ready, 0);
        check("bp_hold", sum, 32'd3);
        out_ready = 1'b1;
        #1 check("bp_release", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("bp_valid_b", out_valid, 1);
        check("bp_sum_b", sum, 32'd30);
        @(negedge clk);
        check("bp_valid_c", out_valid, 1);
        check("bp_sum_c", sum, 32'h300);
        @(negedge clk);
        check("bp_empty", out_valid, 0);

        // Reset while two sets are in flight.
        out_ready = 1'b0; in_valid = 1'b1; a = 32'd5; b = 32'd6;
        @(negedge clk);
        a = 32'd7;
        @(negedge clk);
        in_valid = 1'b0;
        check("mr_pre_valid", out_valid, 1);
        rst_n = 1'b0;
        #1 check("mr_valid", out_valid, 0);
        check("mr_sum", sum, 0);
        check("mr_c_out", c_out, 0);
        check("mr_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        #1 check("mr_in_ready_post", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mr_no_valid", out_valid, 0);
        end

        for (int cyc = 0; cyc < 60000 && got < 10000; cyc++) begin
            @(negedge clk);
            in_valid  = (acc < 10000) && ($urandom_range(0, 3) != 0);
            a         = $urandom;
            b         = $urandom;
            c_in      = 1'($urandom_range(0, 1));
            out_ready = $urandom_range(0, 3) != 0;
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, c_in));
                acc++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("rand_extra", 1, 0);
                else check("rand", {c_out, sum, overflow, zero}, exp_q.pop_front());
                got++;
            end
        end
        check("rand_count", got, 10000);
        check("rand_left", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
